// File: rtl/dcache_axi_bridge.sv
// Bridges whole-line (8 x 32-bit) data-cache refills and writebacks onto single
// 8-beat AXI4 INCR bursts, one transaction at a time, with a one-cycle grant.
module dcache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] wr_line [0:7],
    output logic        gnt,
    output logic [31:0] rd_line [0:7],
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] wbuf [0:7];

    // Response codes and the sub-line address bits carry no meaning for this bridge.
    logic unused_ok;
    assign unused_ok = ^{req_addr[4:0], rresp, bresp};

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arlen   = 8'd7;
    assign awlen   = 8'd7;
    assign arsize  = 3'd2;
    assign awsize  = 3'd2;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wstrb   = 4'hF;
    assign wdata   = wbuf[cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= 1'b0;
            arvalid <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
            rready  <= 1'b0;
            bready  <= 1'b0;
            araddr  <= '0;
            awaddr  <= '0;
            cnt     <= '0;
            for (int i = 0; i < 8; i++) begin
                rd_line[i] <= '0;
                wbuf[i]    <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    // Writeback wins so a dirty victim leaves before its refill.
                    if (wr_req) begin
                        awaddr  <= {req_addr[31:5], 5'b0};
                        wbuf    <= wr_line;
                        awvalid <= 1'b1;
                        state   <= S_AW;
                    end else if (rd_req) begin
                        araddr  <= {req_addr[31:5], 5'b0};
                        arvalid <= 1'b1;
                        state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= '0;
                        state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid && rready) begin
                        rd_line[cnt] <= rdata;
                        cnt          <= cnt + 3'd1;
                        if (rlast) begin
                            rready <= 1'b0;
                            gnt    <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_AW: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= 1'b0;
                        cnt     <= '0;
                        state   <= S_W;
                    end
                end
                S_W: begin
                    if (wvalid && wready) begin
                        cnt   <= cnt + 3'd1;
                        wlast <= (cnt == 3'd6);
                        if (cnt == 3'd7) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (bvalid && bready) begin
                        bready <= 1'b0;
                        gnt    <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Bench for dcache_axi_bridge: a configurable AXI slave, a transaction-level
// reference model checked every cycle, and directed line refill/writeback cases.
module tb_dcache_axi_bridge;

    logic        clk, rst;
    logic [31:0] req_addr;
    logic        rd_req, wr_req;
    logic [31:0] wr_line [0:7];
    logic        gnt;
    logic [31:0] rd_line [0:7];
    logic [3:0]  arid, awid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    dcache_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .req_addr(req_addr), .rd_req(rd_req), .wr_req(wr_req),
        .wr_line(wr_line), .gnt(gnt), .rd_line(rd_line),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Slave behaviour knobs, set by the stimulus process between transactions.
    int          ar_delay = 0, r_toggle = 0, w_stall_beat = -1, w_stall_len = 0, r_last_beat = 7;
    logic [31:0] r_base = '0;

    initial begin : slave
        int s_ar_wait, s_rbeat, s_wbeat, s_wstall;
        bit s_ph, s_ar_hs, s_r_hs, s_rl_hs, s_w_hs, s_rst;
        s_ar_wait = 0; s_rbeat = 0; s_wbeat = 0; s_wstall = 0; s_ph = 0;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 2'b10;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b11;
        forever begin
            @(negedge clk);
            s_ar_hs = arvalid && arready;
            s_r_hs  = rvalid && rready;
            s_rl_hs = rvalid && rready && rlast;
            s_w_hs  = wvalid && wready;
            s_rst   = rst;
            @(posedge clk);
            #1;
            if (s_rst) begin
                s_ar_wait = 0; s_rbeat = 0; s_wbeat = 0; s_wstall = 0;
            end else begin
                if (s_ar_hs) s_ar_wait = 0;
                if (s_r_hs) s_rbeat = s_rl_hs ? 0 : s_rbeat + 1;
                if (s_w_hs) begin
                    s_wbeat  = (s_wbeat == 7) ? 0 : s_wbeat + 1;
                    s_wstall = 0;
                end
            end
            s_ph    = !s_ph;
            arready = arvalid && (s_ar_wait >= ar_delay);
            if (arvalid && !arready) s_ar_wait++;
            rvalid  = rready && (r_toggle == 0 || s_ph);
            rdata   = r_base + s_rbeat * 32'h11;
            rlast   = (s_rbeat == r_last_beat);
            awready = awvalid;
            wready  = wvalid && !(s_wbeat == w_stall_beat && s_wstall < w_stall_len);
            if (wvalid && !wready) s_wstall++;
            bvalid  = bready;
        end
    end

    // Reference model: expected line contents, grant timing and AXI fields.
    logic [31:0] exp_line [0:7];
    logic [31:0] exp_w [0:7];
    logic [31:0] exp_araddr = '0, exp_awaddr = '0, w_hold = '0;
    logic        exp_gnt = 1'b0;
    bit          armed = 0, ar_pend = 0, aw_pend = 0, w_pend = 0, arv_prev = 0;
    int          r_beat = 0, w_beat = 0, ar_cnt = 0, aw_cnt = 0, ar_rise_cyc = 0;
    int          w_stall_seen = 0, ar_wait_seen = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (armed) begin
                check("gnt", gnt, exp_gnt);
                for (int i = 0; i < 8; i++)
                    check($sformatf("rd_line[%0d]", i), rd_line[i], exp_line[i]);
                if (arvalid) begin
                    check("araddr", araddr, exp_araddr);
                    check("arlen", arlen, 8'd7);
                    check("arsize", arsize, 3'd2);
                    check("arburst", arburst, 2'b01);
                    check("arid", arid, 4'd1);
                end
                if (ar_pend) check("arvalid_hold", arvalid, 1'b1);
                if (awvalid) begin
                    check("awaddr", awaddr, exp_awaddr);
                    check("awlen", awlen, 8'd7);
                    check("awsize", awsize, 3'd2);
                    check("awburst", awburst, 2'b01);
                    check("awid", awid, 4'd1);
                end
                if (aw_pend) check("awvalid_hold", awvalid, 1'b1);
                if (wvalid) begin
                    check("wdata", wdata, exp_w[w_beat]);
                    check("wlast", wlast, (w_beat == 7));
                    check("wstrb", wstrb, 4'hF);
                end
                if (w_pend) begin
                    check("wvalid_hold", wvalid, 1'b1);
                    check("wdata_stall", wdata, w_hold);
                end
            end
            if (rst) begin
                for (int i = 0; i < 8; i++) exp_line[i] = '0;
                exp_gnt = 0; r_beat = 0; w_beat = 0;
                ar_pend = 0; aw_pend = 0; w_pend = 0; arv_prev = 0;
                armed = 1;
            end else begin
                exp_gnt = (rvalid && rready && rlast) || (bvalid && bready);
                if (rvalid && rready) begin
                    exp_line[r_beat % 8] = rdata;
                    r_beat = rlast ? 0 : r_beat + 1;
                end
                if (wvalid && wready) w_beat = (w_beat == 7) ? 0 : w_beat + 1;
                if (arvalid && arready) ar_cnt++;
                if (awvalid && awready) aw_cnt++;
                if (arvalid && !arready) ar_wait_seen++;
                if (wvalid && !wready) w_stall_seen++;
                if (arvalid && !arv_prev) ar_rise_cyc = cyc;
                arv_prev = arvalid;
                ar_pend  = arvalid && !arready;
                aw_pend  = awvalid && !awready;
                w_pend   = wvalid && !wready;
                w_hold   = wdata;
            end
        end
    end

    int t0 = 0;

    task automatic start_req(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] wbase);
        @(posedge clk);
        #1;
        req_addr = addr;
        wr_req   = wr;
        rd_req   = rd;
        for (int i = 0; i < 8; i++) wr_line[i] = wbase + i;
        t0 = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) wr_line[i] = 32'hDEAD_0000 + i;
        if (!(wr && rd)) req_addr = 32'hFFFF_FFFF;
    endtask

    task automatic wait_gnt(output int gc);
        gc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) begin
            n_chk++;
            $display("FAIL gnt_timeout: no gnt within 300 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic finish_req();
        @(posedge clk);
        #1;
        rd_req = 0;
        wr_req = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int gc, gc2, aw0, ar0, ws0, aw0b, hit;
        rst = 1; rd_req = 0; wr_req = 0; req_addr = '0;
        for (int i = 0; i < 8; i++) wr_line[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_gnt", gnt, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_rd_line0", rd_line[0], 32'h0);

        // Zero-wait refill
        exp_araddr = 32'h1000_0020;
        start_req(0, 1, 32'h1000_0024, 32'h0);
        wait_gnt(gc);
        check("rd_latency", gc - t0, 10);
        check("ar_start", ar_rise_cyc - t0, 1);
        finish_req();
        @(negedge clk);
        check("rd_line3", rd_line[3], 32'h33);
        check("rd_line7_hold", rd_line[7], 32'h77);

        // Zero-wait writeback, cache line changed after capture
        exp_awaddr = 32'h2000_0040;
        for (int i = 0; i < 8; i++) exp_w[i] = 32'hA0 + i;
        aw0 = aw_cnt;
        start_req(1, 0, 32'h2000_0040, 32'hA0);
        wait_gnt(gc);
        check("wr_latency", gc - t0, 11);
        finish_req();
        check("wr_bursts", aw_cnt - aw0, 1);

        // Backpressure on AR, R and W
        ar_delay = 3; r_toggle = 1; w_stall_beat = 4; w_stall_len = 2; r_base = 32'h0100_0000;
        exp_awaddr = 32'h3000_0000;
        for (int i = 0; i < 8; i++) exp_w[i] = 32'hC0 + i;
        ws0 = w_stall_seen;
        start_req(1, 0, 32'h3000_0000, 32'hC0);
        wait_gnt(gc);
        check("wr_stall_latency", gc - t0, 13);
        finish_req();
        check("w_stall_cycles", w_stall_seen - ws0, 2);
        exp_araddr = 32'h3000_0100;
        ws0 = ar_wait_seen;
        start_req(0, 1, 32'h3000_0104, 32'h0);
        wait_gnt(gc);
        finish_req();
        check("ar_wait_cycles", ar_wait_seen - ws0, 3);
        @(negedge clk);
        check("bp_rd_line7", rd_line[7], 32'h0100_0077);

        // Writeback then refill back to back
        ar_delay = 0; r_toggle = 0; w_stall_beat = -1; w_stall_len = 0; r_base = 32'h0200_0000;
        exp_awaddr = 32'h7000_0000;
        for (int i = 0; i < 8; i++) exp_w[i] = 32'h1111_0000 + i;
        aw0 = aw_cnt;
        start_req(1, 0, 32'h7000_0000, 32'h1111_0000);
        wait_gnt(gc);
        @(posedge clk);
        #1;
        wr_req = 0; rd_req = 1; req_addr = 32'h7000_0040; exp_araddr = 32'h7000_0040; t0 = cyc;
        wait_gnt(gc2);
        check("wb_rf_ar_start", ar_rise_cyc - gc, 2);
        check("wb_rf_rd_latency", gc2 - t0, 10);
        finish_req();
        check("wb_rf_no_dup_write", aw_cnt - aw0, 1);

        // Simultaneous requests, then a read ending with early rlast
        exp_awaddr = 32'h4000_0000; exp_araddr = 32'h4000_0000;
        for (int i = 0; i < 8; i++) exp_w[i] = 32'h2222_0000 + i;
        aw0 = aw_cnt; ar0 = ar_cnt;
        start_req(1, 1, 32'h4000_0000, 32'h2222_0000);
        wait_gnt(gc);
        check("sim_write_first", aw_cnt - aw0, 1);
        check("sim_no_read_yet", ar_cnt - ar0, 0);
        @(posedge clk);
        #1;
        wr_req = 0; r_last_beat = 4; r_base = 32'hB000_0000;
        wait_gnt(gc);
        finish_req();
        check("sim_read_after", ar_cnt - ar0, 1);
        @(negedge clk);
        check("early_rd_line0", rd_line[0], 32'hB000_0000);
        check("early_rd_line4", rd_line[4], 32'hB000_0044);
        check("early_rd_line5_kept", rd_line[5], 32'h0200_0055);
        check("early_rd_line7_kept", rd_line[7], 32'h0200_0077);

        // Reset in the middle of a read burst
        r_last_beat = 7; r_base = 32'h0;
        exp_araddr = 32'h5000_0000;
        start_req(0, 1, 32'h5000_0000, 32'h0);
        hit = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (r_beat == 3) begin
                hit = 1;
                break;
            end
        end
        check("reach_beat3", hit, 1);
        @(posedge clk);
        #1;
        rst = 1; rd_req = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("mid_rst_arvalid", arvalid, 1'b0);
        check("mid_rst_rready", rready, 1'b0);
        check("mid_rst_awvalid", awvalid, 1'b0);
        check("mid_rst_wvalid", wvalid, 1'b0);
        check("mid_rst_bready", bready, 1'b0);
        check("mid_rst_gnt", gnt, 1'b0);
        check("mid_rst_rd_line2", rd_line[2], 32'h0);

        // Recovery read proves the bridge is back in IDLE
        exp_araddr = 32'h6000_0000;
        start_req(0, 1, 32'h6000_001F, 32'h0);
        wait_gnt(gc);
        check("post_rst_latency", gc - t0, 10);
        finish_req();
        @(negedge clk);
        check("post_rst_rd_line6", rd_line[6], 32'h66);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
